// File: rtl/stream_raster_gen_pkg.sv
// Shared types for the stream-to-raster converter: raster FSM states,
// Bayer phase codes and a small sizing helper.
package generic_pack;

    typedef enum logic [2:0] {
        IDLE,
        VBLANK,
        LINE_WAIT,
        ACTIVE,
        HBLANK
    } state_t;

    // Bayer phase is {row[0], col[0]} for a GRBG mosaic
    localparam logic [1:0] BAYER_GR = 2'b00;
    localparam logic [1:0] BAYER_R  = 2'b01;
    localparam logic [1:0] BAYER_B  = 2'b10;
    localparam logic [1:0] BAYER_GB = 2'b11;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/stream_raster_gen_fifo.sv
// raster_fifo: synchronous show-ahead FIFO; o_dout shows the head entry.
// Ports: i_clk, i_rst (async, active-high), i_wr_en/i_din, i_rd_en/o_dout,
// o_full, o_empty, o_count. A write while full is taken only with a pop.
module raster_fifo #(
    parameter int WIDTH = 25,
    parameter int DEPTH = 1024
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_wr_en,
    input  logic [WIDTH-1:0]       i_din,
    input  logic                   i_rd_en,
    output logic [WIDTH-1:0]       o_dout,
    output logic                   o_full,
    output logic                   o_empty,
    output logic [$clog2(DEPTH):0] o_count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_wr;
    logic             w_rd;

    assign o_full  = (r_count == (AW+1)'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_dout  = r_mem[r_rd_ptr];
    assign w_rd    = i_rd_en && !o_empty;
    assign w_wr    = i_wr_en && (!o_full || w_rd);

    always_ff @(posedge i_clk) begin
        if (w_wr) r_mem[r_wr_ptr] <= i_din;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_wr, w_rd})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/stream_raster_gen.sv
// stream_raster_gen: buffers AXI4-Stream pixels and replays them as a
// fvalid/lvalid camera raster with blanking, coordinates and EOF pulse.
// Ports: clk, reset (async, active-high), enable, m_axis_mm2s_* (stream in),
// readyToRead (tready), valid/lvalid/fvalid, red/green/blue/rgb, xCord,
// yCord, endOfFrame, syncError (sticky).
module stream_raster_gen
    import generic_pack::*;
#(
    parameter int IMG_WIDTH   = 640,
    parameter int IMG_HEIGHT  = 480,
    parameter int H_BLANK     = 16,
    parameter int V_BLANK     = 32,
    parameter int PIXEL_WIDTH = 8,
    parameter int DATA_WIDTH  = 32,
    parameter int FIFO_DEPTH  = 1024,
    parameter int BAYER_MODE  = 0,
    localparam int XW = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1,
    localparam int YW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     enable,
    input  logic                     m_axis_mm2s_tvalid,
    input  logic                     m_axis_mm2s_tuser,
    input  logic [DATA_WIDTH-1:0]    m_axis_mm2s_tdata,
    output logic                     readyToRead,
    output logic                     valid,
    output logic [PIXEL_WIDTH-1:0]   red,
    output logic [PIXEL_WIDTH-1:0]   green,
    output logic [PIXEL_WIDTH-1:0]   blue,
    output logic [3*PIXEL_WIDTH-1:0] rgb,
    output logic                     lvalid,
    output logic                     fvalid,
    output logic [XW-1:0]            xCord,
    output logic [YW-1:0]            yCord,
    output logic                     endOfFrame,
    output logic                     syncError
);
    localparam int P   = PIXEL_WIDTH;
    localparam int PW3 = 3 * P;
    localparam int FW  = PW3 + 1;
    localparam int CW  = $clog2(FIFO_DEPTH) + 1;
    localparam int NW  = $clog2(max3(IMG_WIDTH, H_BLANK, V_BLANK) + 1);

    state_t          r_state;
    state_t          w_next;
    logic [NW-1:0]   r_cnt;
    logic [YW-1:0]   r_line;
    logic            w_emit;
    logic            w_discard;
    logic            w_full;
    logic            w_empty;
    logic [CW-1:0]   w_count;
    logic [FW-1:0]   w_head;
    logic [P-1:0]    w_r;
    logic [P-1:0]    w_g;
    logic [P-1:0]    w_b;
    logic [P-1:0]    w_sample;
    logic [PW3-1:0]  w_rgb_next;
    logic [1:0]      w_phase;
    logic            w_px_last;
    logic            w_last_line;

    generate
        if (DATA_WIDTH > PW3) begin : g_hi
            logic [DATA_WIDTH-PW3-1:0] w_unused_hi;
            assign w_unused_hi = m_axis_mm2s_tdata[DATA_WIDTH-1:PW3];
        end
    endgenerate

    assign readyToRead = !w_full;

    raster_fifo #(
        .WIDTH (FW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk   (clk),
        .i_rst   (reset),
        .i_wr_en (m_axis_mm2s_tvalid && !w_full),
        .i_din   ({m_axis_mm2s_tuser, m_axis_mm2s_tdata[PW3-1:0]}),
        .i_rd_en (w_emit || w_discard),
        .o_dout  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    assign w_r         = w_head[3*P-1:2*P];
    assign w_g         = w_head[2*P-1:P];
    assign w_b         = w_head[P-1:0];
    assign w_px_last   = (r_cnt == NW'(IMG_WIDTH - 1));
    assign w_last_line = (r_line == YW'(IMG_HEIGHT - 1));
    assign w_phase     = {r_line[0], r_cnt[0]};

    always_comb begin
        w_next    = r_state;
        w_emit    = 1'b0;
        w_discard = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (enable) w_next = VBLANK;
            end
            VBLANK: begin
                if (r_cnt == NW'(V_BLANK - 1)) w_next = LINE_WAIT;
            end
            LINE_WAIT: begin
                // Drop words until the frame starts on a tuser word
                if (r_line == '0 && !w_empty && !w_head[FW-1])
                    w_discard = 1'b1;
                else if (w_count >= CW'(IMG_WIDTH))
                    w_next = ACTIVE;
            end
            ACTIVE: begin
                w_emit = 1'b1;
                if (w_px_last) w_next = HBLANK;
            end
            HBLANK: begin
                if (r_cnt == NW'(H_BLANK - 1)) begin
                    if (!w_last_line) w_next = LINE_WAIT;
                    else if (enable)  w_next = VBLANK;
                    else              w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        w_sample = w_g;
        unique case (w_phase)
            BAYER_GR: w_sample = w_g;
            BAYER_R:  w_sample = w_r;
            BAYER_B:  w_sample = w_b;
            BAYER_GB: w_sample = w_g;
        endcase
        if (BAYER_MODE != 0) w_rgb_next = PW3'(w_sample);
        else                 w_rgb_next = {w_r, w_g, w_b};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt      <= '0;
            r_line     <= '0;
            fvalid     <= 1'b0;
            lvalid     <= 1'b0;
            valid      <= 1'b0;
            endOfFrame <= 1'b0;
            xCord      <= '0;
            yCord      <= '0;
            red        <= '0;
            green      <= '0;
            blue       <= '0;
            rgb        <= '0;
            syncError  <= 1'b0;
        end else begin
            // One counter serves blanking and pixel position
            r_cnt      <= (w_next != r_state) ? '0 : r_cnt + 1'b1;
            fvalid     <= (r_state == LINE_WAIT) || (r_state == ACTIVE) ||
                          (r_state == HBLANK);
            lvalid     <= w_emit;
            valid      <= w_emit;
            endOfFrame <= w_emit && w_px_last && w_last_line;
            if (r_state == HBLANK && w_next != HBLANK)
                r_line <= w_last_line ? '0 : r_line + 1'b1;
            if (w_emit) begin
                xCord <= r_cnt[XW-1:0];
                yCord <= r_line;
                red   <= w_r;
                green <= w_g;
                blue  <= w_b;
                rgb   <= w_rgb_next;
            end
            if (w_discard) syncError <= 1'b1;
        end
    end

endmodule

// File: tb/tb_stream_raster_gen.sv
// Directed bench for stream_raster_gen: RGB and Bayer instances share
// one stream source; each task checks its scenario inline.
module tb_stream_raster_gen;
    localparam int W  = 4;
    localparam int H  = 2;
    localparam int HB = 2;
    localparam int VB = 3;

    logic        clk = 1'b0;
    logic        reset, enable, tvalid, tuser;
    logic [31:0] tdata;

    logic        rdy, vld, lv, fv, eof, serr;
    logic [7:0]  red, green, blue;
    logic [23:0] rgb;
    logic [1:0]  x;
    logic [0:0]  y;

    logic        b_rdy, b_vld, b_lv, b_fv, b_eof, b_serr;
    logic [7:0]  b_red, b_green, b_blue;
    logic [23:0] b_rgb;
    logic [1:0]  b_x;
    logic [0:0]  b_y;

    int n_pass = 0;
    int n_chk  = 0;

    logic [23:0] s_data[$];
    bit          s_user[$];
    int          s_idx, s_lim;

    bit          c_lv[$], c_fv[$];
    logic [23:0] p_rgb[$], p_brgb[$];
    int          p_x[$], p_y[$];
    bit          p_eof[$];

    always #5 clk = ~clk;

    stream_raster_gen #(
        .IMG_WIDTH(W), .IMG_HEIGHT(H), .H_BLANK(HB), .V_BLANK(VB),
        .PIXEL_WIDTH(8), .DATA_WIDTH(32), .FIFO_DEPTH(8), .BAYER_MODE(0)
    ) u_rgb (
        .clk(clk), .reset(reset), .enable(enable),
        .m_axis_mm2s_tvalid(tvalid), .m_axis_mm2s_tuser(tuser),
        .m_axis_mm2s_tdata(tdata), .readyToRead(rdy), .valid(vld),
        .red(red), .green(green), .blue(blue), .rgb(rgb),
        .lvalid(lv), .fvalid(fv), .xCord(x), .yCord(y),
        .endOfFrame(eof), .syncError(serr)
    );

    stream_raster_gen #(
        .IMG_WIDTH(W), .IMG_HEIGHT(H), .H_BLANK(HB), .V_BLANK(VB),
        .PIXEL_WIDTH(8), .DATA_WIDTH(32), .FIFO_DEPTH(8), .BAYER_MODE(1)
    ) u_bay (
        .clk(clk), .reset(reset), .enable(enable),
        .m_axis_mm2s_tvalid(tvalid), .m_axis_mm2s_tuser(tuser),
        .m_axis_mm2s_tdata(tdata), .readyToRead(b_rdy), .valid(b_vld),
        .red(b_red), .green(b_green), .blue(b_blue), .rgb(b_rgb),
        .lvalid(b_lv), .fvalid(b_fv), .xCord(b_x), .yCord(b_y),
        .endOfFrame(b_eof), .syncError(b_serr)
    );

    task automatic drive_src();
        if (s_idx < s_lim && s_idx < s_data.size()) begin
            tvalid = 1'b1;
            tdata  = {8'h00, s_data[s_idx]};
            tuser  = s_user[s_idx];
        end else begin
            tvalid = 1'b0;
            tdata  = '0;
            tuser  = 1'b0;
        end
    endtask

    task automatic clear_cap();
        c_lv.delete(); c_fv.delete();
        p_rgb.delete(); p_brgb.delete();
        p_x.delete(); p_y.delete(); p_eof.delete();
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            bit acc;
            acc = tvalid && rdy;
            @(posedge clk);
            #1;
            if (acc) s_idx++;
            c_lv.push_back(lv);
            c_fv.push_back(fv);
            if (lv) begin
                p_rgb.push_back(rgb);
                p_brgb.push_back(b_rgb);
                p_x.push_back(int'(x));
                p_y.push_back(int'(y));
                p_eof.push_back(eof);
            end
            drive_src();
        end
    endtask

    task automatic load(input logic [23:0] base, input int n);
        for (int i = 0; i < n; i++) begin
            s_data.push_back(base + 24'(i));
            s_user.push_back(i == 0);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1; enable = 1'b0;
        tvalid = 1'b0; tuser = 1'b0; tdata = '0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        clear_cap();
        s_data.delete(); s_user.delete();
        s_idx = 0; s_lim = 1000;
    endtask

    function automatic int find_edge(input bit fsel, input bit rise,
                                     input int from);
        for (int i = (from < 1) ? 1 : from; i < c_lv.size(); i++) begin
            bit cur, prv;
            cur = fsel ? c_fv[i] : c_lv[i];
            prv = fsel ? c_fv[i-1] : c_lv[i-1];
            if (rise ? (cur && !prv) : (!cur && prv)) return i;
        end
        return -1;
    endfunction

    function automatic logic [23:0] pix(input int i);
        return (i < p_rgb.size()) ? p_rgb[i] : 24'hxxxxxx;
    endfunction

    task automatic test_reset();
        reset = 1'b1; enable = 1'b0;
        tvalid = 1'b0; tuser = 1'b0; tdata = '0;
        #17;
        n_chk++;
        if ({vld, lv, fv, eof, serr} !== 5'b0)
            $display("FAIL reset_ctl got %b want 00000",
                     {vld, lv, fv, eof, serr});
        else n_pass++;
        n_chk++;
        if ({red, green, blue, rgb, x, y} !== '0)
            $display("FAIL reset_data got %0h want 0",
                     {red, green, blue, rgb, x, y});
        else n_pass++;
        n_chk++;
        if (rdy !== 1'b1) $display("FAIL reset_rdy got %b want 1", rdy);
        else n_pass++;
        do_reset();
    endtask

    task automatic test_continuous();
        int r0, f0, r1, f1, fr0, ff0, fr1;
        do_reset();
        load(24'h000001, 8);
        load(24'h000009, 8);
        enable = 1'b1;
        drive_src();
        tick(60);
        for (int i = 0; i < 8; i++) begin
            n_chk++;
            if (pix(i) !== 24'(i + 1))
                $display("FAIL cont_rgb[%0d] got %0h want %0h", i, pix(i), i + 1);
            else n_pass++;
            n_chk++;
            if (i >= p_x.size() || p_x[i] != i % W || p_y[i] != i / W)
                $display("FAIL cont_xy[%0d] want %0d,%0d", i, i % W, i / W);
            else n_pass++;
            n_chk++;
            if (i >= p_eof.size() || p_eof[i] != (i == 7))
                $display("FAIL cont_eof[%0d] want %0d", i, i == 7);
            else n_pass++;
        end
        for (int i = 8; i < 12; i++) begin
            n_chk++;
            if (pix(i) !== 24'(i + 1))
                $display("FAIL cont_f2_rgb[%0d] got %0h want %0h",
                         i, pix(i), i + 1);
            else n_pass++;
        end
        r0  = find_edge(0, 1, 1);
        f0  = find_edge(0, 0, r0);
        r1  = find_edge(0, 1, f0);
        f1  = find_edge(0, 0, r1);
        fr0 = find_edge(1, 1, 1);
        ff0 = find_edge(1, 0, fr0);
        fr1 = find_edge(1, 1, ff0);
        n_chk++;
        if (f0 - r0 != W || f1 - r1 != W)
            $display("FAIL cont_line_len got %0d,%0d want %0d",
                     f0 - r0, f1 - r1, W);
        else n_pass++;
        n_chk++;
        if (r1 - f0 != HB + 1)
            $display("FAIL cont_hgap got %0d want %0d", r1 - f0, HB + 1);
        else n_pass++;
        n_chk++;
        if (!(r0 - fr0 >= 1))
            $display("FAIL cont_fv_to_lv got %0d want >=1", r0 - fr0);
        else n_pass++;
        n_chk++;
        if (ff0 - f1 != HB)
            $display("FAIL cont_lv_to_fv_fall got %0d want %0d", ff0 - f1, HB);
        else n_pass++;
        n_chk++;
        if (fr1 - ff0 != VB)
            $display("FAIL cont_vgap got %0d want %0d", fr1 - ff0, VB);
        else n_pass++;
        n_chk++;
        if (serr !== 1'b0) $display("FAIL cont_serr got %b want 0", serr);
        else n_pass++;
    endtask

    task automatic test_stall();
        int mark, ones, r0, f0, r1, f1;
        do_reset();
        load(24'h000001, 8);
        s_lim = 7;
        enable = 1'b1;
        drive_src();
        tick(40);
        ones = 0;
        foreach (c_lv[i]) ones += int'(c_lv[i]);
        n_chk++;
        if (ones != W) $display("FAIL stall_lv_cycles got %0d want %0d", ones, W);
        else n_pass++;
        n_chk++;
        if (fv !== 1'b1) $display("FAIL stall_fv got %b want 1", fv);
        else n_pass++;
        mark = c_lv.size();
        s_lim = 8;
        drive_src();
        tick(20);
        r0 = find_edge(0, 1, 1);
        f0 = find_edge(0, 0, r0);
        r1 = find_edge(0, 1, f0);
        f1 = find_edge(0, 0, r1);
        n_chk++;
        if (r1 != mark + 2)
            $display("FAIL stall_line1_start got %0d want %0d", r1, mark + 2);
        else n_pass++;
        n_chk++;
        if (f1 - r1 != W)
            $display("FAIL stall_line1_len got %0d want %0d", f1 - r1, W);
        else n_pass++;
        for (int i = 4; i < 8; i++) begin
            n_chk++;
            if (pix(i) !== 24'(i + 1))
                $display("FAIL stall_rgb[%0d] got %0h want %0h", i, pix(i), i + 1);
            else n_pass++;
        end
    endtask

    task automatic test_resync();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            s_data.push_back(24'h0000A1 + 24'(i));
            s_user.push_back(1'b0);
        end
        load(24'h000011, 8);
        enable = 1'b1;
        drive_src();
        tick(50);
        n_chk++;
        if (serr !== 1'b1) $display("FAIL resync_serr got %b want 1", serr);
        else n_pass++;
        n_chk++;
        if (p_rgb.size() != 8)
            $display("FAIL resync_npix got %0d want 8", p_rgb.size());
        else n_pass++;
        for (int i = 0; i < 8; i++) begin
            n_chk++;
            if (pix(i) !== 24'h000011 + 24'(i))
                $display("FAIL resync_rgb[%0d] got %0h want %0h",
                         i, pix(i), 24'h000011 + 24'(i));
            else n_pass++;
        end
    endtask

    task automatic test_bayer();
        logic [7:0] bexp [8];
        bexp = '{8'hBB, 8'hAA, 8'hBB, 8'hAA, 8'hCC, 8'hBB, 8'hCC, 8'hBB};
        do_reset();
        for (int i = 0; i < 8; i++) begin
            s_data.push_back(24'hAABBCC);
            s_user.push_back(i == 0);
        end
        enable = 1'b1;
        drive_src();
        tick(40);
        for (int i = 0; i < 8; i++) begin
            logic [23:0] got;
            got = (i < p_brgb.size()) ? p_brgb[i] : 24'hxxxxxx;
            n_chk++;
            if (got !== {16'h0, bexp[i]})
                $display("FAIL bayer_rgb[%0d] got %0h want %0h", i, got, bexp[i]);
            else n_pass++;
        end
        n_chk++;
        if ({b_red, b_green, b_blue} !== 24'hAABBCC)
            $display("FAIL bayer_chan got %0h want aabbcc",
                     {b_red, b_green, b_blue});
        else n_pass++;
        n_chk++;
        if (pix(0) !== 24'hAABBCC)
            $display("FAIL bayer_rgbmode got %0h want aabbcc", pix(0));
        else n_pass++;
    endtask

    task automatic test_full();
        do_reset();
        load(24'h000021, 10);
        drive_src();
        tick(14);
        n_chk++;
        if (rdy !== 1'b0) $display("FAIL full_rdy got %b want 0", rdy);
        else n_pass++;
        n_chk++;
        if (s_idx != 8) $display("FAIL full_accepted got %0d want 8", s_idx);
        else n_pass++;
        tick(3);
        n_chk++;
        if (s_idx != 8 || tvalid !== 1'b1)
            $display("FAIL full_hold got %0d want 8", s_idx);
        else n_pass++;
        enable = 1'b1;
        tick(40);
        for (int i = 0; i < 8; i++) begin
            n_chk++;
            if (pix(i) !== 24'h000021 + 24'(i))
                $display("FAIL full_rgb[%0d] got %0h want %0h",
                         i, pix(i), 24'h000021 + 24'(i));
            else n_pass++;
        end
    endtask

    task automatic test_reset_mid();
        int  ones;
        bit  hit;
        do_reset();
        load(24'h000001, 16);
        enable = 1'b1;
        drive_src();
        hit = 1'b0;
        for (int i = 0; i < 100 && !hit; i++) begin
            tick(1);
            if (lv && y == 1'b1) hit = 1'b1;
        end
        n_chk++;
        if (!hit) $display("FAIL rmid_reach_line1 got timeout want line 1");
        else n_pass++;
        #2;
        reset = 1'b1;
        #1;
        n_chk++;
        if ({vld, lv, fv, eof, serr} !== 5'b0 || {rgb, red, green, blue, x, y} !== '0)
            $display("FAIL rmid_outputs got %b/%0h want 0",
                     {vld, lv, fv, eof, serr}, {rgb, x, y});
        else n_pass++;
        n_chk++;
        if (rdy !== 1'b1) $display("FAIL rmid_rdy got %b want 1", rdy);
        else n_pass++;
        tvalid = 1'b0; tuser = 1'b0; tdata = '0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        clear_cap();
        s_data.delete(); s_user.delete();
        s_idx = 0; s_lim = 1000;
        enable = 1'b1;
        tick(20);
        ones = 0;
        foreach (c_lv[i]) ones += int'(c_lv[i]);
        n_chk++;
        if (ones != 0) $display("FAIL rmid_fifo_empty got %0d lv want 0", ones);
        else n_pass++;
        n_chk++;
        if (fv !== 1'b1 || serr !== 1'b0)
            $display("FAIL rmid_restart got fv=%b serr=%b want 1,0", fv, serr);
        else n_pass++;
        load(24'h000051, 8);
        drive_src();
        tick(40);
        for (int i = 0; i < 8; i++) begin
            n_chk++;
            if (pix(i) !== 24'h000051 + 24'(i))
                $display("FAIL rmid_rgb[%0d] got %0h want %0h",
                         i, pix(i), 24'h000051 + 24'(i));
            else n_pass++;
        end
        n_chk++;
        if (p_y.size() < 5 || p_y[0] != 0 || p_y[4] != 1 || p_x[0] != 0)
            $display("FAIL rmid_coords want y0=0 y4=1 x0=0");
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_continuous();
        test_stall();
        test_resync();
        test_bayer();
        test_full();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
